uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to uart_tx. It adds configurable data width, parity and stop bits, plus an internal write FIFO so the host can queue several characters without polling tx_busy. It sits between the sensor-hub control logic, which pushes formatted temperature bytes, and the board UART pin. It drives frames back-to-back from the FIFO.

Parameters:
CLK_FREQ, 1_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer, truncated), DIV >= 2 required
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  DATA_BITS  character to queue
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse: write dropped
tx  output  1  serial line, idle high
tx_busy  output  1  high while a frame is on the line (state != IDLE)

Behaviour:
- Reset (rst_n low, async): tx=1, tx_busy=0, state=IDLE, FIFO cleared, level=0, empty=1, full=0, overflow=0, baud and bit counters at 0. Reset mid-frame aborts the frame immediately; tx returns high with no stop bit. Queued data is lost.
- FIFO: circular buffer with wr/rd pointers. level, full and empty are registered and consistent with the pointers after each edge.
  - Write with not full: the entry is stored and level increments.
  - Write when full with no pop in the same cycle: the data is dropped, level is unchanged, and overflow=1 for one cycle.
  - Write and pop in the same cycle: both take effect and level is unchanged. A write when full plus a pop is accepted, with no overflow.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If !empty, pop the head into the shift register, compute the parity bit, clear counters, and go to START.
  - START: tx=0 for DIV cycles, then go to DATA.
  - DATA: tx=shift[0], LSB first, with each bit held DIV cycles. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx = XOR of the data bits for even parity, or its inverse for odd parity, held DIV cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*DIV cycles, then go to IDLE.
- Baud counter: counts 0..DIV-1. The bit advances on the DIV-1 terminal count. The counter restarts at 0 on each state entry.
- Latency: wr_en sampled at edge N into an empty FIFO with the FSM in IDLE. The pop occurs at edge N+1, and tx falls and tx_busy rises after edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles of tx_busy high.
- Back-to-back: after STOP completes, the FSM spends exactly one cycle in IDLE (tx=1, tx_busy=0). It pops on that cycle if !empty, so the inter-frame gap is the stop bits plus 1 clk.
- Values of wr_data are latched at push time. Changes after the push do not affect queued frames.
- The FIFO may be written while a frame is transmitting. The frame in flight is never altered.
- tx is driven from a register: glitch-free, with no combinational path from inputs.

Test Plan:
- 8N1, DIV=104, push 0x55 once. tx falls 2 edges after the wr_en edge. Line sequence is 0,1,0,1,0,1,0,1,0,1 with each bit 104 cycles. tx_busy is high for 1040 cycles, then empty=1 and tx=1.
- PARITY=1 (even), push 0x07: parity bit = 1. PARITY=2 (odd), push 0x07: parity bit = 0. Frame is 1144 cycles. For STOP_BITS=2, the stop level is held 208 cycles.
- FIFO_DEPTH=4, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, starting with the FSM in IDLE.
  - 0x11 is popped at the 2nd edge, so no overflow occurs.
  - Expect full=1 after the 5th write with level=4, and no overflow.
  - A 6th write while full must pulse overflow.
  - Five frames decode in order, each separated by a 1-cycle IDLE gap.
- Push while full in the same cycle as the IDLE pop: the write is accepted, overflow=0, level is unchanged, and the data appears in the final frame.
- Assert rst_n low mid-DATA of frame 2 of 3 queued. tx=1 immediately (asynchronous), tx_busy=0, level=0, empty=1. Output is silent after release until the next push.
- DATA_BITS=7, PARITY=0, push 7'h41: 9-bit frame of 0,1,0,0,0,0,0,1,1, with tx_busy high for 9*DIV cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with an internal write FIFO.
// Frames are sent back-to-back from the FIFO: start bit, DATA_BITS data bits
// (LSB first), optional parity bit, then STOP_BITS stop bits. Each bit lasts
// DIV = CLK_FREQ/BAUD clock cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     push wr_data into the FIFO this cycle
//   wr_data   character to queue
//   full      FIFO holds FIFO_DEPTH entries
//   empty     FIFO holds no entries
//   level     current FIFO occupancy
//   overflow  one-cycle pulse when a write is dropped
//   tx        serial line, idle high, driven from a register
//   tx_busy   high while a frame is on the line
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 1_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx,
    output logic                          tx_busy
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_next;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level_next;
    logic                 pop, push;

    assign pop  = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
    assign push = wr_en && (!full || pop);

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level    <= level_next;
            full     <= (level_next == LVL_W'(FIFO_DEPTH));
            empty    <= (level_next == '0);
            overflow <= wr_en && full && !pop;
        end
    end

    // ---------------- Transmitter ----------------
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 baud_done;

    assign baud_done = (cnt == CNT_W'(DIV - 1));
    assign tx_busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        par_next   = par_bit;
        tx_next    = 1'b1;

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (!empty) begin
                    shift_next = mem[rd_ptr];
                    par_next   = (PARITY == 2) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
                    state_next = S_START;
                end
            end
            S_START: begin
                cnt_next = cnt + CNT_W'(1);
                if (baud_done) begin
                    cnt_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                cnt_next = cnt + CNT_W'(1);
                if (baud_done) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                cnt_next = cnt + CNT_W'(1);
                if (baud_done) begin
                    cnt_next   = '0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                cnt_next = cnt + CNT_W'(1);
                if (baud_done) begin
                    cnt_next = '0;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // tx is registered from the next-state values so the line level
        // changes on the same edge as the state.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            par_bit <= par_next;
            tx      <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four instances (8N1, 8E1, 8O2, 7N1) at DIV=104.
module tb_uart_tx_fifo;

    localparam int DIV = 104;

    logic             clk;
    logic             rst_n;
    logic [3:0]       wr_en;
    logic [2:0][7:0]  wr_data;
    logic [6:0]       wr_data7;
    logic [3:0]       full, empty, overflow, tx, tx_busy;
    logic [3:0][2:0]  level;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(9600), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .full(full[0]), .empty(empty[0]), .level(level[0]), .overflow(overflow[0]),
        .tx(tx[0]), .tx_busy(tx_busy[0]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(9600), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .full(full[1]), .empty(empty[1]), .level(level[1]), .overflow(overflow[1]),
        .tx(tx[1]), .tx_busy(tx_busy[1]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(9600), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_8o2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .full(full[2]), .empty(empty[2]), .level(level[2]), .overflow(overflow[2]),
        .tx(tx[2]), .tx_busy(tx_busy[2]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(9600), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .wr_data(wr_data7),
        .full(full[3]), .empty(empty[3]), .level(level[3]), .overflow(overflow[3]),
        .tx(tx[3]), .tx_busy(tx_busy[3]));

    // 8N1 line image, bit 0 = start bit.
    function automatic logic [15:0] frame_8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Entered at the negedge of frame cycle 'skip'; returns at the negedge of
    // the first cycle after the frame. Counts cycles where tx or tx_busy differ
    // from the expected line image and samples each bit at its midpoint.
    task automatic watch_frame(input int idx, input logic [15:0] bits, input int nbits,
                               input int skip, output int bad, output logic [15:0] got);
        bad = 0;
        got = '0;
        for (int c = skip; c < nbits * DIV; c++) begin
            if (c % DIV == DIV / 2) got[c / DIV] = tx[idx];
            if (tx[idx] !== bits[c / DIV] || tx_busy[idx] !== 1'b1) bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        wr_en    = '0;
        wr_data  = '0;
        wr_data7 = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx[i] !== 1'b1 || tx_busy[i] !== 1'b0 || level[i] !== 3'd0 ||
                empty[i] !== 1'b1 || full[i] !== 1'b0 || overflow[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: tx=%b busy=%b level=%0d empty=%b full=%b ovf=%b, need 1 0 0 1 0 0",
                         i, tx[i], tx_busy[i], level[i], empty[i], full[i], overflow[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_8n1();
        int bad;
        logic [15:0] got;
        wr_en[0] = 1'b1;
        wr_data[0] = 8'h55;
        @(negedge clk);
        wr_en[0] = 1'b0;
        wr_data[0] = 8'hFF;
        checks++;
        if (tx[0] !== 1'b1 || level[0] !== 3'd1 || empty[0] !== 1'b0) begin
            errors++;
            $display("FAIL push_edge: tx=%b level=%0d empty=%b, need 1 1 0", tx[0], level[0], empty[0]);
        end
        @(negedge clk);
        checks++;
        if (tx[0] !== 1'b0 || tx_busy[0] !== 1'b1 || level[0] !== 3'd0 || empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL latency_pop: tx=%b busy=%b level=%0d empty=%b, need 0 1 0 1",
                     tx[0], tx_busy[0], level[0], empty[0]);
        end
        watch_frame(0, 16'b0000_0010_1010_1010, 10, 0, bad, got);
        checks++;
        if (bad !== 0 || got !== 16'h02AA) begin
            errors++;
            $display("FAIL frame_55: bad_cycles=%0d bits=%h, need 0 and 02aa", bad, got);
        end
        checks++;
        if (tx_busy[0] !== 1'b0 || tx[0] !== 1'b1 || empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL end_55: busy=%b tx=%b empty=%b, need 0 1 1", tx_busy[0], tx[0], empty[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_parity();
        int bad;
        logic [15:0] got;
        // even parity, 0x07 -> parity bit 1, 11-bit frame
        wr_en[1] = 1'b1;
        wr_data[1] = 8'h07;
        @(negedge clk);
        wr_en[1] = 1'b0;
        @(negedge clk);
        watch_frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0, bad, got);
        checks++;
        if (bad !== 0 || got[9] !== 1'b1) begin
            errors++;
            $display("FAIL even_parity: bad_cycles=%0d parity=%b, need 0 and 1", bad, got[9]);
        end
        checks++;
        if (tx_busy[1] !== 1'b0 || tx[1] !== 1'b1) begin
            errors++;
            $display("FAIL even_len: busy=%b tx=%b after 1144 cycles, need 0 1", tx_busy[1], tx[1]);
        end
        // odd parity, two stop bits, 0x07 -> parity bit 0, 12-bit frame
        wr_en[2] = 1'b1;
        wr_data[2] = 8'h07;
        @(negedge clk);
        wr_en[2] = 1'b0;
        @(negedge clk);
        watch_frame(2, {4'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 12, 0, bad, got);
        checks++;
        if (bad !== 0 || got[9] !== 1'b0 || got[11:10] !== 2'b11) begin
            errors++;
            $display("FAIL odd_parity_2stop: bad_cycles=%0d parity=%b stops=%b, need 0 0 11",
                     bad, got[9], got[11:10]);
        end
        checks++;
        if (tx_busy[2] !== 1'b0 || tx[2] !== 1'b1) begin
            errors++;
            $display("FAIL odd_len: busy=%b tx=%b after 1248 cycles, need 0 1", tx_busy[2], tx[2]);
        end
        @(negedge clk);
    endtask

    task automatic test_fifo_burst();
        int bad;
        logic [15:0] got;
        logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wr_en[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data[0] = exp_d[i];
            @(negedge clk);
            checks++;
            if (overflow[0] !== 1'b0) begin
                errors++;
                $display("FAIL burst_no_ovf[%0d]: overflow=%b, need 0", i, overflow[0]);
            end
        end
        checks++;
        if (full[0] !== 1'b1 || level[0] !== 3'd4) begin
            errors++;
            $display("FAIL burst_full: full=%b level=%0d, need 1 4", full[0], level[0]);
        end
        wr_data[0] = 8'h66;
        @(negedge clk);
        wr_en[0] = 1'b0;
        checks++;
        if (overflow[0] !== 1'b1 || level[0] !== 3'd4) begin
            errors++;
            $display("FAIL overflow_pulse: overflow=%b level=%0d, need 1 4", overflow[0], level[0]);
        end
        @(negedge clk);
        checks++;
        if (overflow[0] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_one_cycle: overflow=%b, need 0", overflow[0]);
        end
        // first frame started after the 2nd write edge; 5 cycles already elapsed
        for (int f = 0; f < 5; f++) begin
            watch_frame(0, frame_8n1(exp_d[f]), 10, (f == 0) ? 5 : 0, bad, got);
            checks++;
            if (bad !== 0 || got[8:1] !== exp_d[f]) begin
                errors++;
                $display("FAIL burst_frame[%0d]: bad_cycles=%0d data=%h, need 0 and %h",
                         f, bad, got[8:1], exp_d[f]);
            end
            checks++;
            if (tx_busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
                errors++;
                $display("FAIL burst_gap[%0d]: busy=%b tx=%b, need 0 1", f, tx_busy[0], tx[0]);
            end
            @(negedge clk);
        end
        checks++;
        if (empty[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL burst_drained: empty=%b busy=%b, need 1 0", empty[0], tx_busy[0]);
        end
    endtask

    task automatic test_push_full_with_pop();
        int bad;
        int n;
        logic [15:0] got;
        logic [7:0] exp_d [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hB6};
        wr_en[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data[0] = exp_d[i];
            @(negedge clk);
        end
        wr_en[0] = 1'b0;
        n = 0;
        while (tx_busy[0] === 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_busy[0] !== 1'b0 || full[0] !== 1'b1 || level[0] !== 3'd4) begin
            errors++;
            $display("FAIL full_idle_reach: busy=%b full=%b level=%0d, need 0 1 4",
                     tx_busy[0], full[0], level[0]);
        end
        // write lands on the IDLE-pop edge
        wr_en[0] = 1'b1;
        wr_data[0] = exp_d[5];
        @(negedge clk);
        wr_en[0] = 1'b0;
        checks++;
        if (overflow[0] !== 1'b0 || level[0] !== 3'd4 || full[0] !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_full: overflow=%b level=%0d full=%b, need 0 4 1",
                     overflow[0], level[0], full[0]);
        end
        for (int f = 1; f < 6; f++) begin
            watch_frame(0, frame_8n1(exp_d[f]), 10, 0, bad, got);
            checks++;
            if (bad !== 0 || got[8:1] !== exp_d[f]) begin
                errors++;
                $display("FAIL full_frame[%0d]: bad_cycles=%0d data=%h, need 0 and %h",
                         f, bad, got[8:1], exp_d[f]);
            end
            @(negedge clk);
        end
        checks++;
        if (empty[0] !== 1'b1 || tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_drained: empty=%b tx=%b busy=%b, need 1 1 0", empty[0], tx[0], tx_busy[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int bad;
        wr_en[0] = 1'b1;
        wr_data[0] = 8'hC1;
        @(negedge clk);
        wr_data[0] = 8'hC2;
        @(negedge clk);
        wr_data[0] = 8'hC3;
        @(negedge clk);
        wr_en[0] = 1'b0;
        n = 0;
        while (tx_busy[0] === 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        repeat (4 * DIV) @(negedge clk);
        checks++;
        if (tx_busy[0] !== 1'b1 || level[0] !== 3'd1) begin
            errors++;
            $display("FAIL frame2_running: busy=%b level=%0d, need 1 1", tx_busy[0], level[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || level[0] !== 3'd0 || empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: tx=%b busy=%b level=%0d empty=%b, need 1 0 0 1",
                     tx[0], tx_busy[0], level[0], empty[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || level[0] !== 3'd0) begin
            errors++;
            $display("FAIL silent_after_reset: active_cycles=%0d level=%0d, need 0 0", bad, level[0]);
        end
    endtask

    task automatic test_7bit();
        int bad;
        logic [15:0] got;
        wr_en[3] = 1'b1;
        wr_data7 = 7'h41;
        @(negedge clk);
        wr_en[3] = 1'b0;
        @(negedge clk);
        // 0,1,0,0,0,0,0,1,1
        watch_frame(3, 16'b0000_0001_1000_0010, 9, 0, bad, got);
        checks++;
        if (bad !== 0 || got !== 16'h0182) begin
            errors++;
            $display("FAIL frame_7n1: bad_cycles=%0d bits=%h, need 0 and 0182", bad, got);
        end
        checks++;
        if (tx_busy[3] !== 1'b0 || tx[3] !== 1'b1) begin
            errors++;
            $display("FAIL len_7n1: busy=%b tx=%b after 936 cycles, need 0 1", tx_busy[3], tx[3]);
        end
    endtask

    initial begin
        test_reset();
        test_single_8n1();
        test_parity();
        test_fifo_burst();
        test_push_full_with_pop();
        test_reset_mid_frame();
        test_7bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
